// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven-segment scanner: the segment bit order and
// the active-high glyph constants used by the decoder.
// ---------------------------------------------------------------------------
package seven_seg_pkg;

    // Segment bit positions inside a glyph: bit6..bit0 = g,f,e,d,c,b,a.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [6:0] glyph_t;

    // Active-high glyphs (1 = segment lit).
    localparam glyph_t GLYPH_0     = 7'b0111111;
    localparam glyph_t GLYPH_1     = 7'b0000110;
    localparam glyph_t GLYPH_2     = 7'b1011011;
    localparam glyph_t GLYPH_3     = 7'b1001111;
    localparam glyph_t GLYPH_4     = 7'b1100110;
    localparam glyph_t GLYPH_5     = 7'b1101101;
    localparam glyph_t GLYPH_6     = 7'b1111101;
    localparam glyph_t GLYPH_7     = 7'b0000111;
    localparam glyph_t GLYPH_8     = 7'b1111111;
    localparam glyph_t GLYPH_9     = 7'b1101111;
    localparam glyph_t GLYPH_A     = 7'b1110111;
    localparam glyph_t GLYPH_B     = 7'b1111100;
    localparam glyph_t GLYPH_C     = 7'b0111001;
    localparam glyph_t GLYPH_D     = 7'b1011110;
    localparam glyph_t GLYPH_E     = 7'b1111001;
    localparam glyph_t GLYPH_F     = 7'b1110001;
    localparam glyph_t GLYPH_DASH  = 7'b1000000;
    localparam glyph_t GLYPH_BLANK = 7'b0000000;

endpackage : seven_seg_pkg

// File: rtl/seven_seg_scanner_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner_if
// Bundles the scanner's content inputs and display pins.
//   value    : packed nibbles, nibble i is digit i (digit 0 rightmost)
//   load     : capture value/dp_mask/hex_mode/blank_lz into the shadow
//   hex_mode : 1 = hex glyphs, 0 = decimal (10..15 show a dash)
//   blank_lz : 1 = suppress leading zeros
//   dp_mask  : decimal point enable per digit
//   seg/dp/an: display pins (polarity chosen by the scanner)
// master = content producer / pin observer, slave = the scanner.
// ---------------------------------------------------------------------------
interface seven_seg_scanner_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                hex_mode;
    logic                blank_lz;
    logic [DIGITS-1:0]   dp_mask;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;

    modport master (
        output value, load, hex_mode, blank_lz, dp_mask,
        input  seg, dp, an
    );

    modport slave (
        input  value, load, hex_mode, blank_lz, dp_mask,
        output seg, dp, an
    );
endinterface : seven_seg_scanner_if

// File: rtl/seven_seg_scanner_seg_glyph.sv
// ---------------------------------------------------------------------------
// seg_glyph
// Combinational nibble -> active-high seven-segment glyph.
//   nibble   : digit value 0..15
//   hex_mode : 1 = show 0-F, 0 = decimal (10..15 become a dash)
//   blank    : force all segments off
//   glyph    : bit6..bit0 = g,f,e,d,c,b,a, 1 = lit
// ---------------------------------------------------------------------------
module seg_glyph
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    output glyph_t     glyph
);

    always_comb begin
        // NOTE: default assignment first so every path drives glyph and no latch is inferred.
        glyph = GLYPH_BLANK;
        if (!blank) begin
            if (!hex_mode && (nibble >= 4'd10)) begin
                glyph = GLYPH_DASH;
            end else begin
                case (nibble)
                    4'h0: glyph = GLYPH_0;
                    4'h1: glyph = GLYPH_1;
                    4'h2: glyph = GLYPH_2;
                    4'h3: glyph = GLYPH_3;
                    4'h4: glyph = GLYPH_4;
                    4'h5: glyph = GLYPH_5;
                    4'h6: glyph = GLYPH_6;
                    4'h7: glyph = GLYPH_7;
                    4'h8: glyph = GLYPH_8;
                    4'h9: glyph = GLYPH_9;
                    4'hA: glyph = GLYPH_A;
                    4'hB: glyph = GLYPH_B;
                    4'hC: glyph = GLYPH_C;
                    4'hD: glyph = GLYPH_D;
                    4'hE: glyph = GLYPH_E;
                    4'hF: glyph = GLYPH_F;
                    default: glyph = GLYPH_DASH;
                endcase
            end
        end
    end

endmodule : seg_glyph

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplexed multi-digit seven-segment driver. Content is latched into
// shadow registers on load; one digit is shown per refresh slot, with the
// first cycle of each slot keeping all anodes off to avoid ghosting.
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : seven_seg_scanner_if.slave (content inputs, seg/dp/an pins)
// Parameters: DIGITS (1..8), REFRESH_DIV (>=2 cycles per slot),
//             ACTIVE_LOW (1 = pins active-low).
// ---------------------------------------------------------------------------
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_scanner_if.slave  bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam bit INV = (ACTIVE_LOW != 0);

    // Shadow copy of the displayed content.
    logic [4*DIGITS-1:0] sh_value;
    logic [DIGITS-1:0]   sh_dp_mask;
    logic                sh_hex_mode;
    logic                sh_blank_lz;

    // Scan state.
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;

    // Output registers, already in pin polarity.
    logic [6:0]        seg_r;
    logic              dp_r;
    logic [DIGITS-1:0] an_r;

    logic [DIGITS-1:0] lz_mask;
    logic              upper_zero;
    logic [3:0]        sel_nibble;
    logic              sel_blank;
    logic              sel_dp;
    logic [DIGITS-1:0] an_act;
    glyph_t            glyph;

    // Next scan position. Outputs are registered from the next position so
    // that the anode and the glyph for a new slot appear on the same edge.
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        idx_nxt = idx;
        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
    end

    // Leading-zero mask: walk from the top digit down while every nibble seen
    // so far is zero. Digit 0 is never blanked.
    always_comb begin
        // NOTE: upper_zero is a running combinational temporary, so blocking assignment is intended here.
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (sh_value[4*i +: 4] == 4'd0);
            if (i > 0) begin
                lz_mask[i] = sh_blank_lz & upper_zero;
            end
        end
    end

    always_comb begin
        sel_nibble = sh_value[4*int'(idx_nxt) +: 4];
        sel_blank  = lz_mask[idx_nxt];
        sel_dp     = sh_dp_mask[idx_nxt];
        // Count 0 of every slot is the ghost guard: no anode enabled.
        an_act     = (cnt_nxt == '0) ? '0 : (DIGITS'(1) << idx_nxt);
    end

    seg_glyph u_glyph (
        .nibble   (sel_nibble),
        .hex_mode (sh_hex_mode),
        .blank    (sel_blank),
        .glyph    (glyph)
    );

    // Shadow registers: only these feed the display path, so a load never
    // tears a frame with a mix of live and latched inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shadow is reset so the display shows a defined value before the first load.
            sh_value    <= '0;
            sh_dp_mask  <= '0;
            sh_hex_mode <= 1'b0;
            sh_blank_lz <= 1'b0;
        end else if (bus.load) begin
            sh_value    <= bus.value;
            sh_dp_mask  <= bus.dp_mask;
            sh_hex_mode <= bus.hex_mode;
            sh_blank_lz <= bus.blank_lz;
        end
    end

    // Scan counters and output registers; polarity applied here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            seg_r <= {7{INV}};
            dp_r  <= INV;
            an_r  <= {DIGITS{INV}};
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            seg_r <= glyph ^ {7{INV}};
            dp_r  <= sel_dp ^ INV;
            an_r  <= an_act ^ {DIGITS{INV}};
        end
    end

    assign bus.seg = seg_r;
    assign bus.dp  = dp_r;
    assign bus.an  = an_r;

endmodule : seven_seg_scanner
